// File: rtl/bcd_down_counter_pkg.sv
// +-----------------------------------------------------------------+
// | bcd_down_counter_pkg: shared BCD constants and nibble helper    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package bcd_down_counter_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_down_digit.sv
// +-----------------------------------------------------------------+
// | bcd_down_digit: one MOD-10 down-counting digit with borrow out  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module bcd_down_digit
    import bcd_down_counter_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] d,
    input  logic       dec_in,
    output logic [3:0] q,
    output logic       borrow_out
);

    // Borrow ripples combinationally so a whole run of zero digits rolls over in one edge.
    assign borrow_out = dec_in & (q == BCD_ZERO);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= BCD_ZERO;
        end else if (load) begin
            q <= is_bcd(d) ? d : BCD_MAX;
        end else if (dec_in) begin
            q <= (q == BCD_ZERO) ? BCD_MAX : q - 4'd1;
        end
    end

    a_q_is_bcd : assert property (@(posedge clk) disable iff (!clr) is_bcd(q));

endmodule

`default_nettype wire

// File: rtl/bcd_down_counter.sv
// +-----------------------------------------------------------------+
// | bcd_down_counter: cascadable multi-digit BCD down-counter       |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module bcd_down_counter
    import bcd_down_counter_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int SATURATE = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  zero,
    output logic                  tc,
    output logic                  done,
    output logic                  load_err
);

    localparam logic [4*DIGITS-1:0] C_ONE = (4*DIGITS)'(1);

    logic [DIGITS:0]   w_borrow;
    logic [DIGITS-1:0] w_bad_nibble;
    logic              w_dec;
    logic              w_unused_borrow;
    logic              r_done;
    logic              r_load_err;

    assign zero = (bcd == '0);
    assign tc   = en & zero & ~load;

    // In saturating mode the decrement is suppressed at zero, so no digit sees a borrow.
    assign w_dec       = en & ~load & ((SATURATE == 0) || !zero);
    assign w_borrow[0] = w_dec;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .clr        (clr),
            .load       (load),
            .d          (load_val[4*i +: 4]),
            .dec_in     (w_borrow[i]),
            .q          (bcd[4*i +: 4]),
            .borrow_out (w_borrow[i+1])
        );
        assign w_bad_nibble[i] = ~is_bcd(load_val[4*i +: 4]);
    end

    assign w_unused_borrow = w_borrow[DIGITS];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_done     <= w_dec & (bcd == C_ONE);
            r_load_err <= load & (|w_bad_nibble);
        end
    end

    assign done     = r_done;
    assign load_err = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_down_counter.sv
// +-----------------------------------------------------------------+
// | tb_bcd_down_counter: directed table-driven bench                |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_bcd_down_counter;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    // 2-digit saturating
    logic       m_en = 0, m_load = 0;
    logic [7:0] m_val = '0, m_bcd;
    logic       m_zero, m_tc, m_done, m_err;
    // 2-digit wrapping
    logic       wr_en = 0, wr_load = 0;
    logic [7:0] wr_val = '0, wr_bcd;
    logic       wr_zero, wr_tc, wr_done, wr_err;
    // 3-digit saturating
    logic        b3_en = 0, b3_load = 0;
    logic [11:0] b3_val = '0, b3_bcd;
    logic        b3_zero, b3_tc, b3_done, b3_err;
    // cascade: two 1-digit stages plus a 2-digit reference
    logic       cs_en = 0, cs_load = 0;
    logic [3:0] cl_val = '0, ch_val = '0, cl_bcd, ch_bcd;
    logic       cl_zero, cl_tc, cl_done, cl_err, ch_zero, ch_tc, ch_done, ch_err;
    logic [7:0] cr_val = '0, cr_bcd;
    logic       cr_zero, cr_tc, cr_done, cr_err;

    bcd_down_counter #(.DIGITS(2), .SATURATE(1)) u_main (
        .clk(clk), .clr(clr), .en(m_en), .load(m_load), .load_val(m_val),
        .bcd(m_bcd), .zero(m_zero), .tc(m_tc), .done(m_done), .load_err(m_err));
    bcd_down_counter #(.DIGITS(2), .SATURATE(0)) u_wrap (
        .clk(clk), .clr(clr), .en(wr_en), .load(wr_load), .load_val(wr_val),
        .bcd(wr_bcd), .zero(wr_zero), .tc(wr_tc), .done(wr_done), .load_err(wr_err));
    bcd_down_counter #(.DIGITS(3), .SATURATE(1)) u_b3 (
        .clk(clk), .clr(clr), .en(b3_en), .load(b3_load), .load_val(b3_val),
        .bcd(b3_bcd), .zero(b3_zero), .tc(b3_tc), .done(b3_done), .load_err(b3_err));
    bcd_down_counter #(.DIGITS(1), .SATURATE(0)) u_lo (
        .clk(clk), .clr(clr), .en(cs_en), .load(cs_load), .load_val(cl_val),
        .bcd(cl_bcd), .zero(cl_zero), .tc(cl_tc), .done(cl_done), .load_err(cl_err));
    bcd_down_counter #(.DIGITS(1), .SATURATE(0)) u_hi (
        .clk(clk), .clr(clr), .en(cl_tc), .load(cs_load), .load_val(ch_val),
        .bcd(ch_bcd), .zero(ch_zero), .tc(ch_tc), .done(ch_done), .load_err(ch_err));
    bcd_down_counter #(.DIGITS(2), .SATURATE(0)) u_ref (
        .clk(clk), .clr(clr), .en(cs_en), .load(cs_load), .load_val(cr_val),
        .bcd(cr_bcd), .zero(cr_zero), .tc(cr_tc), .done(cr_done), .load_err(cr_err));

    typedef struct {
        int          inst;
        bit          ld;
        bit          en;
        logic [15:0] val;
        bit          tc;
        logic [15:0] bcd;
        bit          done;
        bit          err;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic void add(int inst, bit ld, bit en, logic [15:0] val,
                                bit tc, logic [15:0] bcd, bit done, bit err);
        vec_t v;
        v.inst = inst; v.ld = ld; v.en = en; v.val = val;
        v.tc = tc; v.bcd = bcd; v.done = done; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        m_en = 0; m_load = 0; wr_en = 0; wr_load = 0; b3_en = 0; b3_load = 0;
        case (v.inst)
            0: begin m_en = v.en; m_load = v.ld; m_val = v.val[7:0]; end
            1: begin wr_en = v.en; wr_load = v.ld; wr_val = v.val[7:0]; end
            default: begin b3_en = v.en; b3_load = v.ld; b3_val = v.val[11:0]; end
        endcase
    endtask

    task automatic sample(input int inst, output logic [15:0] b, output logic z,
                          output logic t, output logic d, output logic e);
        case (inst)
            0: begin b = {8'h0, m_bcd}; z = m_zero; t = m_tc; d = m_done; e = m_err; end
            1: begin b = {8'h0, wr_bcd}; z = wr_zero; t = wr_tc; d = wr_done; e = wr_err; end
            default: begin b = {4'h0, b3_bcd}; z = b3_zero; t = b3_tc; d = b3_done; e = b3_err; end
        endcase
    endtask

    task automatic main_state(input string tag, input logic [7:0] b, input logic d, input logic e);
        chk({tag, " bcd"}, {8'h0, m_bcd}, {8'h0, b});
        chk({tag, " zero"}, {15'h0, m_zero}, {15'h0, (b == 8'h00)});
        chk({tag, " done"}, {15'h0, m_done}, {15'h0, d});
        chk({tag, " load_err"}, {15'h0, m_err}, {15'h0, e});
    endtask

    task automatic main_edge(input bit ld, input bit en, input logic [7:0] val);
        @(negedge clk);
        m_load = ld; m_en = en; m_val = val;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] a_b;
    logic a_z, a_t, a_d, a_e;
    logic [7:0] cdown[4] = '{8'h19, 8'h18, 8'h17, 8'h16};

    initial begin
        // main: invalid load with en, hold, load 12, 14 decrements
        add(0, 1, 1, 16'h3C, 0, 16'h39, 0, 1);
        add(0, 0, 0, 16'h00, 0, 16'h39, 0, 0);
        add(0, 1, 0, 16'h12, 0, 16'h12, 0, 0);
        add(0, 0, 1, 0, 0, 16'h11, 0, 0);
        add(0, 0, 1, 0, 0, 16'h10, 0, 0);
        add(0, 0, 1, 0, 0, 16'h09, 0, 0);
        add(0, 0, 1, 0, 0, 16'h08, 0, 0);
        add(0, 0, 1, 0, 0, 16'h07, 0, 0);
        add(0, 0, 1, 0, 0, 16'h06, 0, 0);
        add(0, 0, 1, 0, 0, 16'h05, 0, 0);
        add(0, 0, 1, 0, 0, 16'h04, 0, 0);
        add(0, 0, 1, 0, 0, 16'h03, 0, 0);
        add(0, 0, 1, 0, 0, 16'h02, 0, 0);
        add(0, 0, 1, 0, 0, 16'h01, 0, 0);
        add(0, 0, 1, 0, 0, 16'h00, 1, 0);
        add(0, 0, 1, 0, 1, 16'h00, 0, 0);
        add(0, 0, 1, 0, 1, 16'h00, 0, 0);
        // loads of zero never produce done; load masks tc
        add(0, 1, 0, 16'h05, 0, 16'h05, 0, 0);
        add(0, 1, 0, 16'h00, 0, 16'h00, 0, 0);
        add(0, 1, 1, 16'h00, 0, 16'h00, 0, 0);
        add(0, 1, 0, 16'hF0, 0, 16'h90, 0, 1);
        add(0, 0, 0, 16'h00, 0, 16'h90, 0, 0);
        add(0, 1, 0, 16'h01, 0, 16'h01, 0, 0);
        add(0, 0, 1, 16'h00, 0, 16'h00, 1, 0);
        add(0, 0, 0, 16'h00, 0, 16'h00, 0, 0);
        // wrap mode
        add(1, 1, 1, 16'h01, 0, 16'h01, 0, 0);
        add(1, 0, 1, 0, 0, 16'h00, 1, 0);
        add(1, 0, 1, 0, 1, 16'h99, 0, 0);
        add(1, 0, 1, 0, 0, 16'h98, 0, 0);
        add(1, 0, 0, 0, 0, 16'h98, 0, 0);
        // 3-digit borrow chain
        add(2, 1, 0, 16'h100, 0, 16'h100, 0, 0);
        add(2, 0, 1, 0, 0, 16'h099, 0, 0);
        add(2, 1, 0, 16'h200, 0, 16'h200, 0, 0);
        add(2, 0, 1, 0, 0, 16'h199, 0, 0);
        add(2, 1, 0, 16'h001, 0, 16'h001, 0, 0);
        add(2, 0, 1, 0, 0, 16'h000, 1, 0);
        add(2, 0, 1, 0, 1, 16'h000, 0, 0);

        // reset state, asserted from time zero
        #1;
        main_state("reset", 8'h00, 0, 0);
        chk("reset tc en0", {15'h0, m_tc}, 16'h0);
        m_en = 1;
        #1;
        chk("reset tc en1", {15'h0, m_tc}, 16'h1);
        m_en = 0;
        @(negedge clk);
        clr = 1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            sample(vecs[i].inst, a_b, a_z, a_t, a_d, a_e);
            chk($sformatf("vec%0d tc", i), {15'h0, a_t}, {15'h0, vecs[i].tc});
            @(posedge clk);
            #1;
            sample(vecs[i].inst, a_b, a_z, a_t, a_d, a_e);
            chk($sformatf("vec%0d bcd", i), a_b, vecs[i].bcd);
            chk($sformatf("vec%0d zero", i), {15'h0, a_z}, {15'h0, (vecs[i].bcd == 16'h0)});
            chk($sformatf("vec%0d done", i), {15'h0, a_d}, {15'h0, vecs[i].done});
            chk($sformatf("vec%0d load_err", i), {15'h0, a_e}, {15'h0, vecs[i].err});
        end
        drive(vecs[0]);
        m_en = 0; m_load = 0;

        // asynchronous reset mid-count clears bcd without a clock edge
        main_edge(1, 0, 8'h47);
        main_state("pre-reset", 8'h47, 0, 0);
        @(negedge clk);
        m_load = 0; m_en = 1;
        #2 clr = 0;
        #1;
        main_state("async reset", 8'h00, 0, 0);
        chk("async reset tc", {15'h0, m_tc}, 16'h1);
        m_en = 0;
        @(negedge clk);
        clr = 1;
        main_edge(0, 0, 8'h00);
        main_edge(0, 0, 8'h00);
        main_state("after reset hold", 8'h00, 0, 0);

        // pending load_err and done pulses are cancelled by reset
        main_edge(1, 0, 8'h4F);
        main_state("err pending", 8'h49, 0, 1);
        #1 clr = 0;
        #1;
        main_state("err cancel", 8'h00, 0, 0);
        @(negedge clk);
        clr = 1;
        main_edge(1, 0, 8'h01);
        main_edge(0, 1, 8'h00);
        main_state("done pending", 8'h00, 1, 0);
        #1 clr = 0;
        #1;
        main_state("done cancel", 8'h00, 0, 0);
        m_en = 0;
        @(negedge clk);
        clr = 1;

        // cascade of two 1-digit stages against a 2-digit reference
        @(negedge clk);
        cs_load = 1; cs_en = 1; ch_val = 4'h2; cl_val = 4'h0; cr_val = 8'h20;
        @(posedge clk);
        #1;
        chk("cascade load", {8'h0, ch_bcd, cl_bcd}, 16'h20);
        chk("ref load", {8'h0, cr_bcd}, 16'h20);
        @(negedge clk);
        cs_load = 0;
        #1;
        chk("cascade lo tc", {15'h0, cl_tc}, 16'h1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("cascade step%0d", k), {8'h0, ch_bcd, cl_bcd}, {8'h0, cdown[k]});
            chk($sformatf("cascade vs ref%0d", k), {8'h0, ch_bcd, cl_bcd}, {8'h0, cr_bcd});
        end
        cs_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
